// File: rtl/fibonacci_checker_pkg.sv
// Shared definitions for the Fibonacci stream checker: FSM state encodings and default widths.
package fibonacci_checker_pkg;

  localparam int FIB_WIDTH = 8;
  localparam int FIB_CNT_W = 16;

  typedef enum logic [1:0] {
    S_WAIT0 = 2'd0,
    S_WAIT1 = 2'd1,
    S_RUN   = 2'd2,
    S_ERR   = 2'd3
  } fib_state_t;

endpackage

// File: rtl/fibonacci_checker_next_term.sv
// fib_next_term: WIDTH-bit adder that produces the next Fibonacci term and its carry-out.
module fib_next_term
  import fibonacci_checker_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign sum   = full[WIDTH-1:0];
  assign carry = full[WIDTH];

endmodule

// File: rtl/fibonacci_checker.sv
// Fibonacci stream checker: compares received terms to the expected sequence.
// Optional macro FIB_RESYNC_EN: after a mismatch, hunt for a fresh 0 instead of halting.
module fibonacci_checker
  import fibonacci_checker_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int CNT_W = FIB_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             match,
  output logic             err,
  output logic [WIDTH-1:0] err_data,
  output logic             wrapped,
  output logic [CNT_W-1:0] term_count
);

  fib_state_t       state, state_nxt, err_dst;
  logic [WIDTH-1:0] prev, curr, sum, exp_term;
  logic             carry, acc, hit, drop, miss, hunt;

  fib_next_term #(.WIDTH(WIDTH)) u_next (
    .a     (prev),
    .b     (curr),
    .sum   (sum),
    .carry (carry)
  );

  assign in_ready = (state != S_ERR);
  assign acc      = in_valid & in_ready;

`ifdef FIB_RESYNC_EN
  assign err_dst = S_WAIT0;

  always_ff @(posedge clk) begin
    if (!reset)                         hunt <= 1'b0;
    else if (miss)                      hunt <= 1'b1;
    else if (hit && state == S_WAIT0)   hunt <= 1'b0;
  end
`else
  assign err_dst = S_ERR;
  assign hunt    = 1'b0;
`endif

  always_comb begin
    exp_term = sum;
    case (state)
      S_WAIT0: exp_term = '0;
      S_WAIT1: exp_term = WIDTH'(1);
      default: exp_term = sum;
    endcase
  end

  assign hit  = acc && (in_data == exp_term);
  // While hunting, non-zero terms in S_WAIT0 are swallowed without flagging.
  assign drop = hunt && (state == S_WAIT0);
  assign miss = acc && !hit && !drop;

  always_comb begin
    state_nxt = state;
    if (hit) begin
      case (state)
        S_WAIT0: state_nxt = S_WAIT1;
        S_WAIT1: state_nxt = S_RUN;
        default: state_nxt = state;
      endcase
    end else if (miss) begin
      state_nxt = err_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_WAIT0;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev       <= '0;
      curr       <= '0;
      match      <= 1'b0;
      err        <= 1'b0;
      err_data   <= '0;
      wrapped    <= 1'b0;
      term_count <= '0;
    end else begin
      match <= hit;
      if (hit) begin
        if (term_count != '1) term_count <= term_count + CNT_W'(1);
        case (state)
          S_WAIT0: begin prev <= '0; curr <= '0;        end
          S_WAIT1: begin prev <= '0; curr <= WIDTH'(1); end
          default: begin
            prev <= curr;
            curr <= in_data;
            if (carry) wrapped <= 1'b1;
          end
        endcase
      end
      if (miss) begin
        err <= 1'b1;
        if (!err) err_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Directed bench for fibonacci_checker; expected values are hand-computed Fibonacci terms.
module tb_fibonacci_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        match;
  logic        err;
  logic [7:0]  err_data;
  logic        wrapped;
  logic [15:0] term_count;

  int ntests = 0;
  int nfail  = 0;

  fibonacci_checker dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .match      (match),
    .err        (err),
    .err_data   (err_data),
    .wrapped    (wrapped),
    .term_count (term_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then sample #1 after the edge.
  task automatic step(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic send_match(input string tag, input logic [7:0] d);
    step(1'b1, d);
    chk(tag, match, 1);
  endtask

  logic [7:0] seq [18] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                           8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98,
                           8'd0, 8'd0};

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    @(posedge clk);
    #1;
    do_reset();

    // reset state
    chk("rst_ready", in_ready, 1);
    chk("rst_match", match, 0);
    chk("rst_err", err, 0);
    chk("rst_err_data", err_data, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_count", term_count, 0);

    // first 8 terms
    for (int i = 0; i < 8; i++) send_match($sformatf("seq_match%0d", i), seq[i]);
    chk("seq_count8", term_count, 8);
    chk("seq_err", err, 0);
    chk("seq_nowrap", wrapped, 0);

    // run through the wrap point
    for (int i = 8; i < 14; i++) send_match($sformatf("seq_match%0d", i), seq[i]);
    chk("prewrap", wrapped, 0);
    send_match("wrap_121", seq[14]);
    chk("wrapped_set", wrapped, 1);
    send_match("wrap_98", seq[15]);
    chk("wrap_count", term_count, 16);
    chk("wrap_err", err, 0);

    // idle cycle: no pulse, no state change
    step(1'b0, 8'd55);
    chk("idle_match", match, 0);
    chk("idle_count", term_count, 16);

    // mismatch after 0,1,1,2
    do_reset();
    for (int i = 0; i < 4; i++) send_match($sformatf("pre_err%0d", i), seq[i]);
    step(1'b1, 8'd4);
    chk("mis_match", match, 0);
    chk("mis_err", err, 1);
    chk("mis_err_data", err_data, 4);
    chk("mis_count", term_count, 4);
`ifdef FIB_RESYNC_EN
    chk("rs_ready", in_ready, 1);
    step(1'b1, 8'd7);
    chk("rs_drop7", match, 0);
    step(1'b1, 8'd9);
    chk("rs_drop9", match, 0);
    chk("rs_err_data", err_data, 4);
    send_match("rs_m0", 8'd0);
    send_match("rs_m1", 8'd1);
    send_match("rs_m2", 8'd1);
    chk("rs_count", term_count, 7);
    chk("rs_err_sticky", err, 1);
`else
    chk("halt_ready", in_ready, 0);
    step(1'b1, 8'd3);
    chk("halt_match", match, 0);
    chk("halt_ready2", in_ready, 0);
    chk("halt_err_data", err_data, 4);
    chk("halt_count", term_count, 4);
`endif

    // valid toggling every other cycle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i]);
      chk($sformatf("tog_v%0d", i), match, 1);
      step(1'b0, 8'hAA);
      chk($sformatf("tog_i%0d", i), match, 0);
    end
    chk("tog_count", term_count, 5);

    // reset mid-stream overrides a same-cycle transfer
    do_reset();
    for (int i = 0; i < 3; i++) send_match($sformatf("mid_pre%0d", i), seq[i]);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd2;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("mid_match", match, 0);
    chk("mid_count", term_count, 0);
    chk("mid_err", err, 0);
    chk("mid_wrapped", wrapped, 0);
    chk("mid_err_data", err_data, 0);
    send_match("mid_m0", 8'd0);
    send_match("mid_m1", 8'd1);
    chk("mid_count2", term_count, 2);

    // bad first term
    do_reset();
    step(1'b1, 8'd5);
    chk("first_match", match, 0);
    chk("first_err", err, 1);
    chk("first_err_data", err_data, 5);
    chk("first_count", term_count, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
